// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// the default per-frame timeout budget and the nominal frame length in ticks.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10,
    GAP    = 2'b11
  } state_t;

  localparam int DEFAULT_TIMEOUT_TICKS = 600;
  localparam int FRAME_TICKS           = 529;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side bundle of the scheduler: request levels, flattened payloads
// and the per-requester ack/done pulses returned by the scheduler.
interface uart_tx_sched_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        ack;
  logic [NREQ-1:0]        done;

  modport master (output req, output wdata, input ack, input done);
  modport slave  (input req, input wdata, output ack, output done);
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational rotate-priority picker: the first set request bit found by
// searching upward from ptr+1 (wrapping) wins. Holds no state.
module uart_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] idx_s;

  // Scan from the farthest candidate back to ptr+1 so the nearest one is written last and wins
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx_s  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx_s  = IDX_W'((32'(ptr) + 32'(k)) % 32'(NREQ));
      winner = req[idx_s] ? idx_s : winner;
      valid  = valid | req[idx_s];
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ requesters.
// Optional frame timeout in WAIT is enabled by defining UART_TX_SCHED_TIMEOUT_EN;
// without it WAIT waits indefinitely and timeout_err is constant 0.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int DATA_W        = 32,
  parameter int GAP_TICKS     = 0,
  parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
  localparam int IDX_W        = $clog2(NREQ)
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  uart_tx_sched_if.slave     req_bus,
  input  logic               tick,
  output logic               tx_start,
  output logic [DATA_W-1:0]  tx_data,
  input  logic               tx_done,
  output logic               busy,
  output logic [IDX_W-1:0]   grant_id,
  output logic               timeout_err
);

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t            state_r, state_nxt;
  logic [IDX_W-1:0]  ptr_r, ptr_nxt;
  logic [IDX_W-1:0]  grant_r, grant_nxt;
  logic [DATA_W-1:0] data_r, data_nxt;
  logic [7:0]        gap_cnt_r, gap_cnt_nxt;
  logic              tx_start_r, tx_start_nxt;
  logic              busy_r, busy_nxt;
  logic              tmo_r, tmo_nxt;
  logic [NREQ-1:0]   ack_r, ack_nxt;
  logic [NREQ-1:0]   done_r, done_nxt;
  logic [IDX_W-1:0]  win_s;
  logic              win_valid_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              timeout_s;

  uart_rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req    (req_bus.req),
    .ptr    (ptr_r),
    .winner (win_s),
    .valid  (win_valid_s)
  );

  // Select the winning requester's payload from the flattened bus
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_data_s = (win_s == IDX_W'(i)) ? req_bus.wdata[i*DATA_W +: DATA_W] : sel_data_s;
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  logic [TO_W-1:0] to_cnt_r;

  // Count ticks while waiting for the transmitter; outside WAIT the count is held at zero
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      to_cnt_r <= '0;
    end else if (state_r != WAIT) begin
      to_cnt_r <= '0;
    end else if (tick) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  assign timeout_s = (state_r == WAIT) && tick && (to_cnt_r == TO_W'(TIMEOUT_TICKS - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered from these values
  always_comb begin
    state_nxt    = state_r;
    ptr_nxt      = ptr_r;
    grant_nxt    = grant_r;
    data_nxt     = data_r;
    gap_cnt_nxt  = gap_cnt_r;
    tx_start_nxt = 1'b0;
    ack_nxt      = '0;
    done_nxt     = '0;
    tmo_nxt      = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          state_nxt    = LAUNCH;
          ptr_nxt      = win_s;
          grant_nxt    = win_s;
          data_nxt     = sel_data_s;
          tx_start_nxt = 1'b1;
          ack_nxt      = ONE_HOT0 << win_s;
        end else begin
          state_nxt = IDLE;
        end
      end
      LAUNCH: begin
        // A tx_done seen here belongs to no frame of ours and is dropped
        state_nxt = WAIT;
      end
      WAIT: begin
        if (tx_done || timeout_s) begin
          done_nxt    = ONE_HOT0 << grant_r;
          tmo_nxt     = timeout_s & ~tx_done;
          gap_cnt_nxt = 8'd0;
          state_nxt   = (GAP_TICKS > 0) ? GAP : IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_r == 8'(GAP_TICKS - 1)) begin
            gap_cnt_nxt = 8'd0;
            state_nxt   = IDLE;
          end else begin
            gap_cnt_nxt = gap_cnt_r + 8'd1;
          end
        end else begin
          state_nxt = GAP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers; reset leaves requester 0 first in line
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r    <= IDLE;
      ptr_r      <= IDX_W'(NREQ - 1);
      grant_r    <= '0;
      data_r     <= '0;
      gap_cnt_r  <= 8'd0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      tmo_r      <= 1'b0;
      ack_r      <= '0;
      done_r     <= '0;
    end else begin
      state_r    <= state_nxt;
      ptr_r      <= ptr_nxt;
      grant_r    <= grant_nxt;
      data_r     <= data_nxt;
      gap_cnt_r  <= gap_cnt_nxt;
      tx_start_r <= tx_start_nxt;
      busy_r     <= busy_nxt;
      tmo_r      <= tmo_nxt;
      ack_r      <= ack_nxt;
      done_r     <= done_nxt;
    end
  end

  assign tx_start     = tx_start_r;
  assign tx_data      = data_r;
  assign busy         = busy_r;
  assign grant_id     = grant_r;
  assign timeout_err  = tmo_r;
  assign req_bus.ack  = ack_r;
  assign req_bus.done = done_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched. Main instance uses GAP_TICKS=0 and
// TIMEOUT_TICKS=20; a second instance with GAP_TICKS=3 covers the idle gap.
// The timeout scenario is compiled only with UART_TX_SCHED_TIMEOUT_EN.
module tb_uart_tx_sched;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        tick;
  logic        tx_done, tx_done_g;
  logic        tx_start, tx_start_g;
  logic [31:0] tx_data, tx_data_g;
  logic        busy, busy_g;
  logic [1:0]  grant_id, grant_g;
  logic        timeout_err, timeout_err_g;
  logic        tmo_seen = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  uart_tx_sched_if #(.NREQ(4), .DATA_W(32)) bus ();
  uart_tx_sched_if #(.NREQ(4), .DATA_W(32)) bus_g ();

  uart_tx_sched #(.NREQ(4), .DATA_W(32), .GAP_TICKS(0), .TIMEOUT_TICKS(20)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req_bus(bus), .tick(tick),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  uart_tx_sched #(.NREQ(4), .DATA_W(32), .GAP_TICKS(3), .TIMEOUT_TICKS(600)) dut_g (
    .PCLK(PCLK), .PRESETn(PRESETn), .req_bus(bus_g), .tick(tick),
    .tx_start(tx_start_g), .tx_data(tx_data_g), .tx_done(tx_done_g),
    .busy(busy_g), .grant_id(grant_g), .timeout_err(timeout_err_g)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) if (timeout_err === 1'b1) tmo_seen = 1'b1;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; tick = 1'b0; tx_done = 1'b0; tx_done_g = 1'b0;
    bus.req = 4'b0000; bus.wdata = '0; bus_g.req = 4'b0000; bus_g.wdata = '0;
    repeat (3) @(posedge PCLK);
    #1;
    n_checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: start/busy=%b%b expected 00", tx_start, busy); end
    n_checks++; if (bus.ack !== 4'b0 || bus.done !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: ack=%b done=%b expected 0000/0000", bus.ack, bus.done); end
    n_checks++; if (tx_data !== 32'h0 || grant_id !== 2'd0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_data: data=%h grant=%0d tmo=%b expected 0/0/0", tx_data, grant_id, timeout_err); end
    PRESETn = 1'b1;
    step();
  endtask

  task automatic test_single();
    bus.req = 4'b0001;
    bus.wdata[31:0] = 32'hA5A5_0F0F;
    step();
    n_checks++; if (tx_start !== 1'b1 || bus.ack !== 4'b0001) begin n_fail++; $display("FAIL single_launch: start=%b ack=%b expected 1/0001", tx_start, bus.ack); end
    n_checks++; if (tx_data !== 32'hA5A5_0F0F || grant_id !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_data: data=%h grant=%0d busy=%b expected a5a50f0f/0/1", tx_data, grant_id, busy); end
    bus.req = 4'b0000;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    n_checks++; if (bus.done !== 4'b0000 || busy !== 1'b1 || tx_start !== 1'b0) begin n_fail++; $display("FAIL launch_done_ignored: done=%b busy=%b start=%b expected 0000/1/0", bus.done, busy, tx_start); end
    step();
    n_checks++; if (tx_data !== 32'hA5A5_0F0F || bus.ack !== 4'b0000) begin n_fail++; $display("FAIL wait_hold: data=%h ack=%b expected a5a50f0f/0000", tx_data, bus.ack); end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    n_checks++; if (bus.done !== 4'b0001 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: done=%b busy=%b expected 0001/0", bus.done, busy); end
    step();
    n_checks++; if (bus.done !== 4'b0000 || busy !== 1'b0 || tx_start !== 1'b0) begin n_fail++; $display("FAIL single_idle: done=%b busy=%b start=%b expected 0000/0/0", bus.done, busy, tx_start); end
  endtask

  task automatic test_round_robin();
    int   exp_order[5] = '{0, 1, 2, 3, 0};
    logic found;
    PRESETn = 1'b0;
    step();
    PRESETn = 1'b1;
    for (int i = 0; i < 4; i++) bus.wdata[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        step();
        if (tx_start === 1'b1) found = 1'b1;
      end
      n_checks++; if (!found || grant_id !== 2'(exp_order[g]) || tx_data !== 32'hC0DE_0000 + 32'(exp_order[g])) begin n_fail++; $display("FAIL rr_grant%0d: found=%b grant=%0d data=%h expected grant %0d", g, found, grant_id, tx_data, exp_order[g]); end
      n_checks++; if (bus.ack !== (4'b0001 << exp_order[g])) begin n_fail++; $display("FAIL rr_ack%0d: ack=%b expected requester %0d", g, bus.ack, exp_order[g]); end
      step();
      n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rr_start_held%0d: start=%b expected 0", g, tx_start); end
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      if (g == 4) bus.req = 4'b0000;
      n_checks++; if (bus.done !== (4'b0001 << exp_order[g])) begin n_fail++; $display("FAIL rr_done%0d: done=%b expected requester %0d", g, bus.done, exp_order[g]); end
    end
    step();
  endtask

  task automatic test_gap();
    logic found;
    int   ticks;
    int   cyc;
    bus_g.wdata[31:0] = 32'h1111_1111;
    bus_g.wdata[63:32] = 32'h2222_2222;
    bus_g.req = 4'b0011;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (tx_start_g === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found || grant_g !== 2'd0) begin n_fail++; $display("FAIL gap_first: found=%b grant=%0d expected 1/0", found, grant_g); end
    repeat (2) step();
    tx_done_g = 1'b1;
    step();
    tx_done_g = 1'b0;
    n_checks++; if (bus_g.done !== 4'b0001 || busy_g !== 1'b1) begin n_fail++; $display("FAIL gap_done: done=%b busy=%b expected 0001/1", bus_g.done, busy_g); end
    ticks = 0;
    cyc = 0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (tx_start_g === 1'b1) begin
        found = 1'b1;
      end else begin
        tick = (c % 4 == 1);
        if (tick) ticks++;
        cyc++;
        step();
      end
    end
    tick = 1'b0;
    bus_g.req = 4'b0000;
    n_checks++; if (!found || ticks != 3) begin n_fail++; $display("FAIL gap_ticks: found=%b ticks=%0d expected 3", found, ticks); end
    n_checks++; if (cyc != 11 || grant_g !== 2'd1 || tx_data_g !== 32'h2222_2222) begin n_fail++; $display("FAIL gap_next: cycles=%0d grant=%0d data=%h expected 11/1/22222222", cyc, grant_g, tx_data_g); end
    step();
    tx_done_g = 1'b1;
    step();
    tx_done_g = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick = (c % 2 == 0);
      step();
      if (busy_g === 1'b0) found = 1'b1;
    end
    tick = 1'b0;
    n_checks++; if (!found) begin n_fail++; $display("FAIL gap_drain: busy=%b expected 0", busy_g); end
  endtask

  task automatic test_reset_mid();
    logic found;
    logic done_seen;
    bus.req = 4'b0110;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (tx_start === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found || grant_id !== 2'd1) begin n_fail++; $display("FAIL mid_grant: found=%b grant=%0d expected 1/1", found, grant_id); end
    step();
    #3;
    PRESETn = 1'b0;
    tx_done = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || tx_start !== 1'b0 || grant_id !== 2'd0 || tx_data !== 32'h0) begin n_fail++; $display("FAIL mid_async: busy=%b start=%b grant=%0d data=%h expected all 0", busy, tx_start, grant_id, tx_data); end
    done_seen = (bus.done !== 4'b0000);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    tx_done = 1'b0;
    bus.req = 4'b0111;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (bus.done !== 4'b0000) done_seen = 1'b1;
      step();
      if (tx_start === 1'b1) found = 1'b1;
    end
    n_checks++; if (done_seen) begin n_fail++; $display("FAIL mid_no_done: done pulse seen=%b expected 0", done_seen); end
    n_checks++; if (!found || grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_regrant: found=%b grant=%0d expected 1/0", found, grant_id); end
    bus.req = 4'b0000;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    n_checks++; if (bus.done !== 4'b0001) begin n_fail++; $display("FAIL mid_done: done=%b expected 0001", bus.done); end
  endtask

  task automatic test_withdraw();
    logic found;
    logic ack2_seen;
    ack2_seen = 1'b0;
    bus.req = 4'b1110;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (tx_start === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found || grant_id !== 2'd1) begin n_fail++; $display("FAIL wd_grant: found=%b grant=%0d expected 1/1", found, grant_id); end
    bus.req = 4'b1100;
    step();
    bus.req = 4'b1000;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (bus.ack[2] === 1'b1) ack2_seen = 1'b1;
      if (tx_start === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found || grant_id !== 2'd3 || bus.ack !== 4'b1000) begin n_fail++; $display("FAIL wd_next: found=%b grant=%0d ack=%b expected 1/3/1000", found, grant_id, bus.ack); end
    n_checks++; if (ack2_seen) begin n_fail++; $display("FAIL wd_no_ack2: ack2 seen=%b expected 0", ack2_seen); end
    bus.req = 4'b0000;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wd_idle: busy=%b expected 0", busy); end
  endtask

`ifdef UART_TX_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic found;
    logic early;
    int   ticks;
    bus.wdata[31:0] = 32'h0BAD_F00D;
    bus.req = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (tx_start === 1'b1) found = 1'b1;
    end
    bus.req = 4'b0000;
    n_checks++; if (!found || grant_id !== 2'd0) begin n_fail++; $display("FAIL to_grant: found=%b grant=%0d expected 1/0", found, grant_id); end
    ticks = 0;
    early = 1'b0;
    for (int c = 0; c < 200 && ticks < 20; c++) begin
      tick = (c % 2 == 1);
      if (tick) ticks++;
      step();
      if (ticks < 20 && (timeout_err !== 1'b0 || bus.done !== 4'b0000)) early = 1'b1;
    end
    tick = 1'b0;
    n_checks++; if (early) begin n_fail++; $display("FAIL to_early: early pulse=%b expected 0", early); end
    n_checks++; if (timeout_err !== 1'b1 || bus.done !== 4'b0001) begin n_fail++; $display("FAIL to_pulse: tmo=%b done=%b expected 1/0001", timeout_err, bus.done); end
    step();
    n_checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL to_idle: tmo=%b busy=%b expected 0/0", timeout_err, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_gap();
    test_reset_mid();
    test_withdraw();
`ifdef UART_TX_SCHED_TIMEOUT_EN
    test_timeout();
`else
    n_checks++; if (tmo_seen !== 1'b0) begin n_fail++; $display("FAIL tmo_tied: timeout_err seen=%b expected 0", tmo_seen); end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmitter among NREQ requesters on the APB clock domain. It accepts 32-bit words from requesters, launches one frame at a time through the transmitter's start/data inputs, and waits for the transmitter's done pulse. It then returns a per-requester completion pulse and enforces a programmable inter-frame gap. It sits between the APB-side producers and the UART TX datapath, and drives that datapath's Txstart and PWDATA.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 32, frame payload width; matches transmitter data width
GAP_TICKS, 0, baud ticks of forced idle after each frame (0..255)
TIMEOUT_TICKS, 600, tick budget per frame; used only with the optional feature (full frame = 529 ticks)

Ports:
PCLK  in  1  system clock
PRESETn  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request level
wdata  in  NREQ*DATA_W  flattened payloads; requester i occupies bits [i*DATA_W +: DATA_W]
ack  out  NREQ  one-cycle pulse: word of requester i latched
done  out  NREQ  one-cycle pulse: frame of requester i finished
tick  in  1  baud oversample tick (same tick that drives the transmitter)
tx_start  out  1  one-cycle start pulse to transmitter
tx_data  out  DATA_W  registered payload to transmitter
tx_done  in  1  transmitter frame-complete pulse
busy  out  1  high whenever state is not IDLE
grant_id  out  clog2(NREQ)  index of current/last granted requester
timeout_err  out  1  one-cycle pulse on frame timeout; tied 0 when the optional feature is compiled out

Behaviour:
- Interface: one clock PCLK; reset PRESETn is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; round-robin pointer = NREQ-1, so requester 0 wins first; gap counter 0.
- State machine with four states:
  - IDLE: if any req bit is set, pick the first set bit searching upward from pointer+1 (wrapping). Register tx_data = wdata[winner], grant_id = winner, pointer = winner, then go to LAUNCH.
  - LAUNCH: exactly one cycle. tx_start = 1 and ack[grant_id] = 1, then go to WAIT.
  - WAIT: hold tx_data stable. When tx_done = 1, pulse done[grant_id] for one cycle (registered, same edge as leaving WAIT). Go to GAP if GAP_TICKS > 0, else IDLE.
  - GAP: count tick pulses; after GAP_TICKS ticks return to IDLE.
- Latency: req seen in IDLE at edge n gives tx_start/ack high during cycle n+1. A done pulse occurs the cycle after tx_done is sampled.
- Requester rules:
  - Requester holds req and wdata until it sees ack.
  - Deasserting req before ack withdraws the request with no side effect.
  - req still high after ack is treated as a new request.
- Requests arriving in LAUNCH, WAIT or GAP wait for IDLE; req is sampled only in IDLE.
- tx_done outside WAIT is ignored.
- tx_done in the same cycle as the LAUNCH state is ignored; only a WAIT-state tx_done counts.
- Simultaneous requests: strict rotation. Requester i cannot win twice in a row while any other requester is requesting.
- Reset mid-frame: the FSM returns to IDLE immediately, in-flight ack/done are dropped, and no done pulse is issued for the aborted frame.
- tx_start is never high for more than one consecutive cycle. The transmitter would re-trigger on a held start.

Optional Feature:
- Macro UART_TX_SCHED_TIMEOUT_EN.
- When defined: WAIT counts tick pulses. If the count reaches TIMEOUT_TICKS without tx_done:
  - timeout_err and done[grant_id] pulse together for one cycle;
  - the FSM proceeds to GAP/IDLE as on normal completion;
  - the counter clears on entry to WAIT.
- When not defined: WAIT waits indefinitely, no counter is built, and timeout_err is constant 0.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'b00, LAUNCH=2'b01, WAIT=2'b10, GAP=2'b11);
  - default TIMEOUT_TICKS;
  - frame tick count constant (529).
- One sub-module, uart_rr_arbiter: combinational rotate-priority pick from req and pointer, giving the winner index and a valid flag. All state stays in uart_tx_sched.

Test Plan:
- Single request: req=4'b0001, wdata[0]=32'hA5A5_0F0F. Expect: ack[0] one cycle after req; tx_start one cycle with tx_data=32'hA5A5_0F0F; done[0] one cycle after tx_done; busy low afterward.
- All four requesting continuously from reset. Expect grant order 0,1,2,3,0. Each tx_start is separated by a tx_done; no requester is granted twice consecutively.
- GAP_TICKS=3 with back-to-back requests. Expect exactly 3 tick pulses between done[i] and the next tx_start.
- PRESETn asserted during WAIT. Expect all outputs 0 asynchronously, no done pulse, and the next grant after release goes to requester 0.
- req[2] dropped while WAIT serves requester 1. Expect requester 2 never acked; next grant goes to requester 3 if it is requesting.
- With UART_TX_SCHED_TIMEOUT_EN and TIMEOUT_TICKS=20, tx_done never driven. Expect timeout_err and done[i] pulsed together on the 20th tick, then the FSM returns to IDLE.
